// File: rtl/alrd_rr_arb.sv
// alrd_rr_arb: round-robin arbiter sharing one AL read channel among
// SLAVE_COUNT requesters.
//
// Requests are registered onto m_al_ar* with the winning index as arid.
// Each requester has an outstanding-read counter that caps it at
// MAX_OUTSTANDING reads. Responses are routed back by m_al_rid.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   sn_al_araddr      packed requester word addresses (slice i = requester i)
//   sn_al_arvalid     per-requester request valid
//   sn_al_arready     one-hot grant, combinational
//   sn_al_rdata       m_al_rdata replicated to every requester
//   sn_al_rvalid      one-hot response valid, combinational
//   sn_al_rready      per-requester response ready
//   m_al_araddr       registered word address
//   m_al_arvalid      registered request valid
//   m_al_arid         registered requester index
//   m_al_arready      target accepts the request
//   m_al_rdata        response data
//   m_al_rvalid       response valid
//   m_al_rid          response requester index
//   m_al_rready       response ready
//   rsp_err           one-cycle pulse after an unexpected response is consumed
//   busy              request register full or any outstanding count non-zero
module alrd_rr_arb #(
  parameter int DATA_BITS       = 2,
  parameter int DATA_WIDTH      = 8 << DATA_BITS,
  parameter int ADDR_WIDTH      = 4,
  parameter int SLAVE_COUNT     = 4,
  parameter int ID_BITS         = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [SLAVE_COUNT*(ADDR_WIDTH-DATA_BITS)-1:0] sn_al_araddr,
  input  logic [SLAVE_COUNT-1:0]                      sn_al_arvalid,
  output logic [SLAVE_COUNT-1:0]                      sn_al_arready,
  output logic [SLAVE_COUNT*DATA_WIDTH-1:0]           sn_al_rdata,
  output logic [SLAVE_COUNT-1:0]                      sn_al_rvalid,
  input  logic [SLAVE_COUNT-1:0]                      sn_al_rready,
  output logic [ADDR_WIDTH-DATA_BITS-1:0]             m_al_araddr,
  output logic                                        m_al_arvalid,
  output logic [ID_BITS-1:0]                          m_al_arid,
  input  logic                                        m_al_arready,
  input  logic [DATA_WIDTH-1:0]                       m_al_rdata,
  input  logic                                        m_al_rvalid,
  input  logic [ID_BITS-1:0]                          m_al_rid,
  output logic                                        m_al_rready,
  output logic                                        rsp_err,
  output logic                                        busy
);

  localparam int AW = ADDR_WIDTH - DATA_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_OUTSTANDING);
  localparam logic [ID_BITS-1:0]  LAST_RST = ID_BITS'(SLAVE_COUNT - 1);

  logic [CNT_BITS-1:0]    cnt     [SLAVE_COUNT];
  logic [CNT_BITS-1:0]    cnt_nxt [SLAVE_COUNT];
  logic [ID_BITS-1:0]     last;

  logic [SLAVE_COUNT-1:0] rid_hit;
  logic                   rid_ok;
  logic                   rid_cnt_zero;
  logic                   rid_rready;
  logic                   rsp_route;
  logic                   rsp_unexp;
  logic [SLAVE_COUNT-1:0] dec;

  logic                   load;
  logic [SLAVE_COUNT-1:0] elig;
  logic                   hi_found;
  logic                   lo_found;
  logic [ID_BITS-1:0]     hi_idx;
  logic [ID_BITS-1:0]     lo_idx;
  logic                   grant_valid;
  logic [ID_BITS-1:0]     grant_idx;
  logic [SLAVE_COUNT-1:0] grant_oh;
  logic [AW-1:0]          grant_addr;
  logic                   arvalid_nxt;
  logic                   any_cnt_nxt;

  assign sn_al_rdata = {SLAVE_COUNT{m_al_rdata}};

  // ---------------------------------------------------------------
  // Response routing. The rid lookup is done by comparison rather than
  // array indexing so that out-of-range ids are detected cleanly for
  // non power-of-two SLAVE_COUNT.
  // ---------------------------------------------------------------
  always_comb begin
    rid_hit      = '0;
    rid_ok       = 1'b0;
    rid_cnt_zero = 1'b1;
    rid_rready   = 1'b0;
    for (int unsigned i = 0; i < SLAVE_COUNT; i++) begin
      if (m_al_rid == ID_BITS'(i)) begin
        rid_hit[i]   = 1'b1;
        rid_ok       = 1'b1;
        rid_cnt_zero = (cnt[i] == '0);
        rid_rready   = sn_al_rready[i];
      end
    end
  end

  // A response is expected only if its requester has a read in flight;
  // anything else is swallowed (rready forced high) and flagged.
  assign rsp_route   = !rst && m_al_rvalid && rid_ok && !rid_cnt_zero;
  assign rsp_unexp   = !rst && m_al_rvalid && (!rid_ok || rid_cnt_zero);
  assign m_al_rready = rsp_unexp || (!rst && rid_ok && !rid_cnt_zero && rid_rready);

  always_comb begin
    sn_al_rvalid = '0;
    dec          = '0;
    for (int unsigned i = 0; i < SLAVE_COUNT; i++) begin
      sn_al_rvalid[i] = rsp_route && rid_hit[i];
      dec[i]          = rsp_route && rid_hit[i] && rid_rready;
    end
  end

  // ---------------------------------------------------------------
  // Arbitration. Round-robin from last+1 is split into two fixed-priority
  // scans: indices above last first, then the whole vector as the wrap.
  // A same-cycle decrement makes a saturated requester eligible again.
  // ---------------------------------------------------------------
  assign load = !m_al_arvalid || m_al_arready;

  always_comb begin
    elig     = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < SLAVE_COUNT; i++) begin
      elig[i] = sn_al_arvalid[i] && ((cnt[i] < CNT_MAX) || dec[i]);
    end
    for (int unsigned i = 0; i < SLAVE_COUNT; i++) begin
      if (!hi_found && elig[i] && (ID_BITS'(i) > last)) begin
        hi_found = 1'b1;
        hi_idx   = ID_BITS'(i);
      end
      if (!lo_found && elig[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_BITS'(i);
      end
    end
  end

  assign grant_valid = !rst && load && (hi_found || lo_found);
  assign grant_idx   = hi_found ? hi_idx : lo_idx;

  always_comb begin
    grant_oh   = '0;
    grant_addr = '0;
    for (int unsigned i = 0; i < SLAVE_COUNT; i++) begin
      if (grant_valid && (grant_idx == ID_BITS'(i))) begin
        grant_oh[i] = 1'b1;
        grant_addr  = sn_al_araddr[i*AW +: AW];
      end
    end
  end

  assign sn_al_arready = grant_oh;

  // ---------------------------------------------------------------
  // Outstanding counters: increment on grant, decrement on routed
  // response handshake; both together cancel out.
  // ---------------------------------------------------------------
  always_comb begin
    any_cnt_nxt = 1'b0;
    for (int unsigned i = 0; i < SLAVE_COUNT; i++) begin
      cnt_nxt[i] = cnt[i];
      if (grant_oh[i] && !dec[i]) begin
        cnt_nxt[i] = cnt[i] + CNT_BITS'(1);
      end else if (dec[i] && !grant_oh[i]) begin
        cnt_nxt[i] = cnt[i] - CNT_BITS'(1);
      end
      any_cnt_nxt = any_cnt_nxt || (cnt_nxt[i] != '0);
    end
  end

  assign arvalid_nxt = load ? grant_valid : m_al_arvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_al_arvalid <= 1'b0;
      m_al_araddr  <= '0;
      m_al_arid    <= '0;
      last         <= LAST_RST;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      for (int unsigned i = 0; i < SLAVE_COUNT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      m_al_arvalid <= arvalid_nxt;
      if (grant_valid) begin
        m_al_araddr <= grant_addr;
        m_al_arid   <= grant_idx;
        last        <= grant_idx;
      end
      for (int unsigned i = 0; i < SLAVE_COUNT; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      rsp_err <= rsp_unexp;
      // Built from next-state values so busy tracks the registers it summarises.
      busy    <= arvalid_nxt || any_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_alrd_rr_arb.sv
module tb_alrd_rr_arb;

  typedef struct packed {
    logic [3:0] addr;
    logic [1:0] id;
  } req_t;

  logic         clk = 1'b0;
  logic         rst;

  // Main instance: 4 requesters, limit 2, 4-bit word address
  logic [15:0]  sn_al_araddr;
  logic [3:0]   sn_al_arvalid;
  logic [3:0]   sn_al_arready;
  logic [127:0] sn_al_rdata;
  logic [3:0]   sn_al_rvalid;
  logic [3:0]   sn_al_rready;
  logic [3:0]   m_al_araddr;
  logic         m_al_arvalid;
  logic [1:0]   m_al_arid;
  logic         m_al_arready;
  logic [31:0]  m_al_rdata;
  logic         m_al_rvalid;
  logic [1:0]   m_al_rid;
  logic         m_al_rready;
  logic         rsp_err;
  logic         busy;

  // Second instance: 3 requesters, so rid=3 is out of range
  logic [5:0]   b_sn_al_araddr;
  logic [2:0]   b_sn_al_arvalid;
  logic [2:0]   b_sn_al_arready;
  logic [95:0]  b_sn_al_rdata;
  logic [2:0]   b_sn_al_rvalid;
  logic [2:0]   b_sn_al_rready;
  logic [1:0]   b_m_al_araddr;
  logic         b_m_al_arvalid;
  logic [1:0]   b_m_al_arid;
  logic         b_m_al_arready;
  logic [31:0]  b_m_al_rdata;
  logic         b_m_al_rvalid;
  logic [1:0]   b_m_al_rid;
  logic         b_m_al_rready;
  logic         b_rsp_err;
  logic         b_busy;

  int tests = 0;
  int fails = 0;
  req_t exp_q[$];

  alrd_rr_arb #(
    .DATA_BITS(2), .ADDR_WIDTH(6), .SLAVE_COUNT(4), .MAX_OUTSTANDING(2)
  ) u_dut (
    .clk(clk), .rst(rst),
    .sn_al_araddr(sn_al_araddr), .sn_al_arvalid(sn_al_arvalid),
    .sn_al_arready(sn_al_arready), .sn_al_rdata(sn_al_rdata),
    .sn_al_rvalid(sn_al_rvalid), .sn_al_rready(sn_al_rready),
    .m_al_araddr(m_al_araddr), .m_al_arvalid(m_al_arvalid),
    .m_al_arid(m_al_arid), .m_al_arready(m_al_arready),
    .m_al_rdata(m_al_rdata), .m_al_rvalid(m_al_rvalid),
    .m_al_rid(m_al_rid), .m_al_rready(m_al_rready),
    .rsp_err(rsp_err), .busy(busy)
  );

  alrd_rr_arb #(
    .DATA_BITS(2), .ADDR_WIDTH(4), .SLAVE_COUNT(3), .MAX_OUTSTANDING(4)
  ) u_dut3 (
    .clk(clk), .rst(rst),
    .sn_al_araddr(b_sn_al_araddr), .sn_al_arvalid(b_sn_al_arvalid),
    .sn_al_arready(b_sn_al_arready), .sn_al_rdata(b_sn_al_rdata),
    .sn_al_rvalid(b_sn_al_rvalid), .sn_al_rready(b_sn_al_rready),
    .m_al_araddr(b_m_al_araddr), .m_al_arvalid(b_m_al_arvalid),
    .m_al_arid(b_m_al_arid), .m_al_arready(b_m_al_arready),
    .m_al_rdata(b_m_al_rdata), .m_al_rvalid(b_m_al_rvalid),
    .m_al_rid(b_m_al_rid), .m_al_rready(b_m_al_rready),
    .rsp_err(b_rsp_err), .busy(b_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] addr_of(input int i);
    return 4'(i * 3 + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i);
    req_t r;
    r.addr = addr_of(i);
    r.id   = 2'(i);
    exp_q.push_back(r);
  endtask

  initial begin
    rst             = 1'b1;
    sn_al_araddr    = {addr_of(3), addr_of(2), addr_of(1), addr_of(0)};
    sn_al_arvalid   = 4'hF;
    sn_al_rready    = 4'hF;
    m_al_arready    = 1'b1;
    m_al_rdata      = 32'h1234_5678;
    m_al_rvalid     = 1'b1;
    m_al_rid        = 2'd0;
    b_sn_al_araddr  = '0;
    b_sn_al_arvalid = '0;
    b_sn_al_rready  = '0;
    b_m_al_arready  = 1'b0;
    b_m_al_rdata    = '0;
    b_m_al_rvalid   = 1'b0;
    b_m_al_rid      = '0;

    // Scoreboard monitor: pops one expected request per accepted m_al_ar beat
    fork
      forever begin
        @(negedge clk);
        if (!rst && m_al_arvalid && m_al_arready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected_accept: got addr=%0h id=%0h expected no request",
                     m_al_araddr, m_al_arid);
          end else begin
            req_t e;
            e = exp_q.pop_front();
            chk("sb_req", 64'({m_al_araddr, m_al_arid}), 64'({e.addr, e.id}));
          end
        end
      end
    join_none

    // Reset with all inputs active: every output must stay 0
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_arready", 64'(sn_al_arready), 64'(0));
      chk("rst_arvalid", 64'(m_al_arvalid), 64'(0));
      chk("rst_araddr",  64'(m_al_araddr), 64'(0));
      chk("rst_arid",    64'(m_al_arid), 64'(0));
      chk("rst_rvalid",  64'(sn_al_rvalid), 64'(0));
      chk("rst_rready",  64'(m_al_rready), 64'(0));
      chk("rst_rsp_err", 64'(rsp_err), 64'(0));
      chk("rst_busy",    64'(busy), 64'(0));
      step();
    end
    rst          = 1'b0;
    m_al_rvalid  = 1'b0;

    // Fairness: all requesting, limit 2 -> 0,1,2,3,0,1,2,3 then stall
    for (int c = 0; c < 8; c++) push(c % 4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("fair_grant", 64'(sn_al_arready), (c < 8) ? 64'(4'b0001 << (c % 4)) : 64'(0));
      if (c == 9) begin
        chk("fair_empty", 64'(m_al_arvalid), 64'(0));
        chk("fair_busy",  64'(busy), 64'(1));
      end
      step();
    end
    sn_al_arvalid = 4'h0;

    // Routing: rid=2 held off by sn_al_rready[2]=0
    m_al_rvalid  = 1'b1;
    m_al_rid     = 2'd2;
    m_al_rdata   = 32'hDEAD_BEEF;
    sn_al_rready = 4'b0000;
    @(negedge clk);
    chk("route_rready_low", 64'(m_al_rready), 64'(0));
    chk("route_rvalid",     64'(sn_al_rvalid), 64'(4'b0100));
    chk("route_rdata",      64'(sn_al_rdata[95:64]), 64'(32'hDEAD_BEEF));
    step();
    sn_al_rready = 4'b0100;
    @(negedge clk);
    chk("route_rready_high", 64'(m_al_rready), 64'(1));
    chk("route_rvalid2",     64'(sn_al_rvalid), 64'(4'b0100));
    step();
    // cnt[2] is now 1: exactly one more grant to requester 2
    m_al_rvalid   = 1'b0;
    sn_al_rready  = 4'b0000;
    sn_al_arvalid = 4'b0100;
    push(2);
    @(negedge clk);
    chk("dec_regrant", 64'(sn_al_arready), 64'(4'b0100));
    step();
    @(negedge clk);
    chk("dec_relimit", 64'(sn_al_arready), 64'(0));
    step();
    sn_al_arvalid = 4'h0;

    // Drain all outstanding reads: two per requester
    sn_al_rready = 4'hF;
    m_al_rvalid  = 1'b1;
    for (int j = 0; j < 8; j++) begin
      m_al_rid = 2'(j / 2);
      @(negedge clk);
      chk("drain_rready",  64'(m_al_rready), 64'(1));
      chk("drain_rvalid",  64'(sn_al_rvalid), 64'(4'b0001 << (j / 2)));
      chk("drain_rsp_err", 64'(rsp_err), 64'(0));
      step();
    end
    m_al_rvalid = 1'b0;
    @(negedge clk);
    chk("drain_busy", 64'(busy), 64'(0));
    step();

    // Unexpected: rid=0 with cnt[0]=0
    m_al_rvalid  = 1'b1;
    m_al_rid     = 2'd0;
    sn_al_rready = 4'b0000;
    @(negedge clk);
    chk("unexp_rready", 64'(m_al_rready), 64'(1));
    chk("unexp_rvalid", 64'(sn_al_rvalid), 64'(0));
    step();
    m_al_rvalid = 1'b0;
    @(negedge clk);
    chk("unexp_err_pulse", 64'(rsp_err), 64'(1));
    step();
    @(negedge clk);
    chk("unexp_err_clear", 64'(rsp_err), 64'(0));
    chk("unexp_busy",      64'(busy), 64'(0));
    step();

    // Backpressure: last=2, so requester 3 wins, then target stalls 5 cycles
    sn_al_arvalid = 4'hF;
    m_al_arready  = 1'b0;
    push(3);
    @(negedge clk);
    chk("bp_first_grant", 64'(sn_al_arready), 64'(4'b1000));
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_arready", 64'(sn_al_arready), 64'(0));
      chk("bp_arvalid", 64'(m_al_arvalid), 64'(1));
      chk("bp_araddr",  64'(m_al_araddr), 64'(addr_of(3)));
      chk("bp_arid",    64'(m_al_arid), 64'(3));
      step();
    end
    m_al_arready = 1'b1;
    push(0);
    @(negedge clk);
    chk("bp_release_grant", 64'(sn_al_arready), 64'(4'b0001));
    step();
    sn_al_arvalid = 4'h0;
    step();

    // Outstanding limit on requester 1 (cnt[1]=0, last=0)
    sn_al_arvalid = 4'b0010;
    push(1);
    @(negedge clk);
    chk("lim_grant1", 64'(sn_al_arready), 64'(4'b0010));
    step();
    push(1);
    @(negedge clk);
    chk("lim_grant2", 64'(sn_al_arready), 64'(4'b0010));
    step();
    @(negedge clk);
    chk("lim_blocked", 64'(sn_al_arready), 64'(0));
    step();
    m_al_rvalid  = 1'b1;
    m_al_rid     = 2'd1;
    sn_al_rready = 4'b0010;
    push(1);
    @(negedge clk);
    chk("lim_release_grant",  64'(sn_al_arready), 64'(4'b0010));
    chk("lim_release_rready", 64'(m_al_rready), 64'(1));
    step();
    m_al_rvalid  = 1'b0;
    sn_al_rready = 4'b0000;
    @(negedge clk);
    chk("lim_still_full", 64'(sn_al_arready), 64'(0));
    step();
    sn_al_arvalid = 4'h0;
    step();
    step();

    // Out-of-range rid on the 3-requester instance
    b_m_al_rvalid = 1'b1;
    b_m_al_rid    = 2'd3;
    @(negedge clk);
    chk("oor_rready", 64'(b_m_al_rready), 64'(1));
    chk("oor_rvalid", 64'(b_sn_al_rvalid), 64'(0));
    step();
    b_m_al_rvalid = 1'b0;
    @(negedge clk);
    chk("oor_err_pulse", 64'(b_rsp_err), 64'(1));
    step();
    @(negedge clk);
    chk("oor_err_clear", 64'(b_rsp_err), 64'(0));
    chk("oor_busy",      64'(b_busy), 64'(0));
    step();

    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
